polyline_sequencer: RTL
=======================

POLYLINE_SEQUENCER -- requirements
Module: polyline_sequencer

Interface
REQ-001 Parameter WDOG_CYCLES, default 8192: maximum unpaused cycles allowed per segment before abort-with-error.
REQ-002 clk  in  1  system clock; every register samples on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  shape command offered.
REQ-005 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-006 cmd_shape  in  2  0=line, 1=triangle outline, 2=box outline, 3=reserved.
REQ-007 v0x, v0y, v1x, v1y, v2x, v2y  in  12 each, signed  vertex coordinates; v2 is used only by triangle.
REQ-008 abort  in  1  cancel the current shape.
REQ-009 pix_full  in  1  downstream pixel writer cannot accept.
REQ-010 lg_run  out  1  one-cycle start pulse to the line generator.
REQ-011 lg_reset  out  1  one-cycle synchronous reset to the line generator.
REQ-012 lg_aX, lg_aY, lg_bX, lg_bY  out  12 each, signed  segment endpoints.
REQ-013 lg_ena_pause  out  1  pause to the line generator.
REQ-014 lg_busy, lg_line_complete  in  1 each  line generator status.
REQ-015 seg_idx  out  2  index of the current segment.
REQ-016 shape_done  out  1  one-cycle pulse when a shape completes normally.
REQ-017 shape_err  out  1  one-cycle pulse on a reserved shape or watchdog abort.

Function
REQ-018 States: IDLE, LAUNCH, WAIT_DONE, WAIT_IDLE, FLUSH.
REQ-019 IDLE: cmd_ready=1; cmd_valid latches cmd_shape and all six vertices; seg_idx<=0; shape 0-2 -> LAUNCH; shape 3 -> pulse shape_err, stay in IDLE.
REQ-020 cmd_ready shall be 0 in all states other than IDLE.
REQ-021 Segment count: line=1, triangle=3, box=4.
REQ-022 Line segment 0: (v0x,v0y)->(v1x,v1y).
REQ-023 Triangle segments: v0->v1, v1->v2, v2->v0.
REQ-024 Box segments, corners from latched v0/v1: (v0x,v0y)->(v1x,v0y), (v1x,v0y)->(v1x,v1y), (v1x,v1y)->(v0x,v1y), (v0x,v1y)->(v0x,v0y).
REQ-025 lg_aX..lg_bY shall be registered and valid in the same cycle lg_run is high; they shall hold until the next LAUNCH.
REQ-026 LAUNCH: lg_run=1 for exactly one cycle -> WAIT_DONE; the watchdog is cleared.
REQ-027 WAIT_DONE: on lg_line_complete=1 -> WAIT_IDLE.
REQ-028 WAIT_IDLE: on lg_busy=0, if seg_idx is the last segment, pulse shape_done and go to IDLE; otherwise seg_idx+1 and go to LAUNCH.
REQ-029 Zero-length segments (point) shall be launched normally; no segment is skipped, even for degenerate boxes or triangles.
REQ-030 lg_ena_pause = pix_full, combinational, in all states.
REQ-031 Watchdog: a 14-bit counter increments in WAIT_DONE while pix_full=0 and saturates; reaching WDOG_CYCLES -> FLUSH with shape_err pulse.
REQ-032 abort=1 in any non-IDLE state -> FLUSH, with no shape_err; abort in IDLE is ignored and a simultaneous cmd_valid is not accepted.
REQ-033 FLUSH: lg_reset=1 for one cycle, then IDLE; no shape_done.
REQ-034 If lg_line_complete and abort coincide, abort wins.
REQ-035 shape_done and shape_err shall never be high in the same cycle.

Reset
REQ-036 On reset assertion: state=IDLE, cmd_ready=1, lg_run=0, lg_reset=0, seg_idx=0, shape_done=0, shape_err=0, endpoints=0, watchdog=0; reset takes effect immediately and asynchronously, and a shape in progress is discarded.

Verification
REQ-037 Line v0=(10,20), v1=(13,20) -> one lg_run with endpoints (10,20,13,20); shape_done follows lg_busy falling; seg_idx stays 0.
REQ-038 Box v0=(0,0), v1=(5,3) -> four launches in order (0,0,5,0), (5,0,5,3), (5,3,0,3), (0,3,0,0), then shape_done.
REQ-039 Triangle v0=(1,1), v1=(4,1), v2=(1,4) with pix_full toggling every 3 cycles -> lg_ena_pause mirrors pix_full; three segments complete; no shape_err.
REQ-040 Box v0=v1=(7,7) -> four point segments launched, then shape_done.
REQ-041 abort during segment 1 of a box -> lg_reset pulse; return to IDLE; no shape_done or shape_err; the next command is accepted.
REQ-042 WDOG_CYCLES=16 with lg_line_complete held low -> shape_err on the 16th unpaused cycle, then lg_reset, then IDLE; cmd_shape=3 -> shape_err and no lg_run.

Source files
------------

// File: rtl/polyline_sequencer.sv
// Breaks line/triangle/box commands into one line-generator launch per segment; endpoints are registered.
// Accepts a command only when idle; pix_full pauses the generator and the watchdog; abort or a timeout flushes.
module polyline_sequencer #(
    parameter int WDOG_CYCLES = 8192
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_shape,
    input  logic signed [11:0] v0x,
    input  logic signed [11:0] v0y,
    input  logic signed [11:0] v1x,
    input  logic signed [11:0] v1y,
    input  logic signed [11:0] v2x,
    input  logic signed [11:0] v2y,
    input  logic               abort,
    input  logic               pix_full,
    output logic               lg_run,
    output logic               lg_reset,
    output logic signed [11:0] lg_aX,
    output logic signed [11:0] lg_aY,
    output logic signed [11:0] lg_bX,
    output logic signed [11:0] lg_bY,
    output logic               lg_ena_pause,
    input  logic               lg_busy,
    input  logic               lg_line_complete,
    output logic [1:0]         seg_idx,
    output logic               shape_done,
    output logic               shape_err
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, WAIT_IDLE, FLUSH} state_t;

    typedef struct packed {
        logic signed [11:0] v0x, v0y, v1x, v1y, v2x, v2y;
    } verts_t;

    typedef struct packed {
        logic signed [11:0] ax, ay, bx, by;
    } seg_t;

    localparam logic [1:0] SHAPE_TRI  = 2'd1;
    localparam logic [1:0] SHAPE_BOX  = 2'd2;
    localparam logic [1:0] SHAPE_RSVD = 2'd3;

    state_t      state;
    logic [1:0]  shape_q;
    verts_t      verts_q;
    verts_t      cmd_verts;
    seg_t        seg_q;
    logic [13:0] wdog;
    logic [13:0] wdog_inc;
    logic        wdog_hit;

    // Box corners run c0=(v0x,v0y) -> c1=(v1x,v0y) -> c2=(v1x,v1y) -> c3=(v0x,v1y) -> c0.
    function automatic seg_t seg_ends(input logic [1:0] shape, input logic [1:0] idx, input verts_t v);
        seg_t s;
        s = '{v.v0x, v.v0y, v.v1x, v.v1y};
        if (shape == SHAPE_TRI) begin
            case (idx)
                2'd1:    s = '{v.v1x, v.v1y, v.v2x, v.v2y};
                2'd2:    s = '{v.v2x, v.v2y, v.v0x, v.v0y};
                default: s = '{v.v0x, v.v0y, v.v1x, v.v1y};
            endcase
        end else if (shape == SHAPE_BOX) begin
            case (idx)
                2'd0:    s = '{v.v0x, v.v0y, v.v1x, v.v0y};
                2'd1:    s = '{v.v1x, v.v0y, v.v1x, v.v1y};
                2'd2:    s = '{v.v1x, v.v1y, v.v0x, v.v1y};
                default: s = '{v.v0x, v.v1y, v.v0x, v.v0y};
            endcase
        end
        return s;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] shape);
        case (shape)
            SHAPE_TRI: return 2'd2;
            SHAPE_BOX: return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    assign cmd_verts    = '{v0x, v0y, v1x, v1y, v2x, v2y};
    assign cmd_ready    = (state == IDLE) && !abort;
    assign lg_ena_pause = pix_full;
    assign lg_aX        = seg_q.ax;
    assign lg_aY        = seg_q.ay;
    assign lg_bX        = seg_q.bx;
    assign lg_bY        = seg_q.by;
    assign wdog_inc     = (wdog == 14'h3fff) ? wdog : wdog + 14'd1;
    assign wdog_hit     = (int'(wdog) + 1) >= WDOG_CYCLES;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shape_q    <= '0;
            verts_q    <= '0;
            seg_q      <= '0;
            seg_idx    <= '0;
            wdog       <= '0;
            lg_run     <= 1'b0;
            lg_reset   <= 1'b0;
            shape_done <= 1'b0;
            shape_err  <= 1'b0;
        end else begin
            lg_run     <= 1'b0;
            lg_reset   <= 1'b0;
            shape_done <= 1'b0;
            shape_err  <= 1'b0;
            // Abort outranks completion and timeout; FLUSH already leads back to IDLE.
            if (abort && state != IDLE && state != FLUSH) begin
                state    <= FLUSH;
                lg_reset <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid && cmd_ready) begin
                            shape_q <= cmd_shape;
                            verts_q <= cmd_verts;
                            seg_idx <= 2'd0;
                            if (cmd_shape == SHAPE_RSVD) begin
                                shape_err <= 1'b1;
                            end else begin
                                state  <= LAUNCH;
                                lg_run <= 1'b1;
                                seg_q  <= seg_ends(cmd_shape, 2'd0, cmd_verts);
                            end
                        end
                    end
                    LAUNCH: begin
                        state <= WAIT_DONE;
                        wdog  <= '0;
                    end
                    WAIT_DONE: begin
                        if (lg_line_complete) begin
                            state <= WAIT_IDLE;
                        end else if (!pix_full) begin
                            wdog <= wdog_inc;
                            if (wdog_hit) begin
                                state     <= FLUSH;
                                lg_reset  <= 1'b1;
                                shape_err <= 1'b1;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (!lg_busy) begin
                            if (seg_idx == last_idx(shape_q)) begin
                                state      <= IDLE;
                                shape_done <= 1'b1;
                            end else begin
                                state   <= LAUNCH;
                                lg_run  <= 1'b1;
                                seg_idx <= seg_idx + 2'd1;
                                seg_q   <= seg_ends(shape_q, seg_idx + 2'd1, verts_q);
                            end
                        end
                    end
                    FLUSH:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
